// File: rtl/count_display.sv
// -----------------------------------------------------------------------------
// count_display
//
// Takes a 32-bit binary value from the counter stage when asked to, converts it
// to 10-digit packed BCD, and scans the low 8 digits onto a multiplexed,
// active-low seven-segment display.
//
// The conversion is a sequential shift-add-3 (double-dabble) engine that runs
// one iteration per clock for 32 clocks. The display always shows the last
// completed conversion.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   : leading-zero digits (digit 1 and up) are blanked; digit 0 always
//               shows its value, so a zero result shows a single "0".
//   undefined : every scanned digit shows its decoded value, zeros included.
//
// Parameters
//   SCAN_DIV   clock cycles each digit stays enabled (must be >= 2)
//
// Ports
//   i_clk      clock; all state updates on the rising edge
//   i_reset    synchronous active-high reset
//   i_result   [31:0] binary value to convert
//   i_load     capture request; ignored while o_busy is high
//   o_busy     conversion in progress
//   o_valid    one-cycle pulse when o_bcd / o_ovf update
//   o_bcd      [39:0] packed BCD, digit k in bits [4k+3:4k], digit 0 = units
//   o_ovf      value >= 10^8, so the 8-digit display is truncated
//   o_an       [7:0] digit enables, active-low, bit i = digit i
//   o_seg      [6:0] segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module count_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_result,
    input  logic        i_load,
    output logic        o_busy,
    output logic        o_valid,
    output logic [39:0] o_bcd,
    output logic        o_ovf,
    output logic [7:0]  o_an,
    output logic [6:0]  o_seg
);

    localparam int             PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Conversion state
    // ------------------------------------------------------------------
    state_t       r_state;
    state_t       w_state_next;
    logic [31:0]  r_bin;
    logic [31:0]  w_bin_next;
    logic [39:0]  r_work;
    logic [39:0]  w_work_next;
    logic [4:0]   r_iter;
    logic [4:0]   w_iter_next;
    logic [39:0]  r_bcd;
    logic [39:0]  w_bcd_next;
    logic         r_ovf;
    logic         w_ovf_next;
    logic         r_valid;
    logic         w_valid_next;

    logic [39:0]  w_adj;
    logic [71:0]  w_shift;

    // Add-3 correction: any nibble >= 5 would become >= 10 after doubling,
    // so bias it by 3 to push the carry into the next decimal digit.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_work[4*gi +: 4] >= 4'd5)
                                    ? (r_work[4*gi +: 4] + 4'd3)
                                    : r_work[4*gi +: 4];
        end
    endgenerate

    // {bcd_work, bin} shifted left by one as a single 72-bit word.
    assign w_shift = {w_adj, r_bin} << 1;

    always_comb begin
        w_state_next = r_state;
        w_bin_next   = r_bin;
        w_work_next  = r_work;
        w_iter_next  = r_iter;
        w_bcd_next   = r_bcd;
        w_ovf_next   = r_ovf;
        w_valid_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_load) begin
                    w_bin_next   = i_result;
                    w_work_next  = '0;
                    w_iter_next  = '0;
                    w_state_next = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                w_bin_next  = w_shift[31:0];
                w_work_next = w_shift[71:32];
                w_iter_next = r_iter + 5'd1;
                // Iteration 31 is the last shift; publish its result directly.
                if (r_iter == 5'd31) begin
                    w_bcd_next   = w_shift[71:32];
                    w_ovf_next   = |w_shift[71:64];
                    w_valid_next = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_bin   <= '0;
            r_work  <= '0;
            r_iter  <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_bin   <= w_bin_next;
            r_work  <= w_work_next;
            r_iter  <= w_iter_next;
            r_bcd   <= w_bcd_next;
            r_ovf   <= w_ovf_next;
            r_valid <= w_valid_next;
        end
    end

    // ------------------------------------------------------------------
    // Display scanning
    // ------------------------------------------------------------------
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_next;
    logic          w_presc_wrap;
    logic [2:0]    r_index;
    logic [2:0]    w_index_next;
    logic [7:0]    r_an;
    logic [7:0]    w_an_next;
    logic [6:0]    r_seg;
    logic [6:0]    w_seg_next;
    logic [3:0]    w_digits [10];
    logic [3:0]    w_digit;
    logic          w_blank;

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_digits
            assign w_digits[gi] = r_bcd[4*gi +: 4];
        end
    endgenerate

    assign w_presc_wrap = (r_presc == PRESC_LAST);
    assign w_presc_next = w_presc_wrap ? '0 : (r_presc + 1'b1);
    assign w_index_next = w_presc_wrap ? (r_index + 3'd1) : r_index;

    // an/seg are driven from the index being loaded on this edge so both
    // outputs move together on the wrap edge.
    assign w_digit   = w_digits[{1'b0, w_index_next}];
    assign w_an_next = ~(8'b1 << w_index_next);

`ifdef LEADING_ZERO_BLANK_EN
    // w_upper_zero[i] is set when digits i..9 are all zero.
    logic [9:0] w_upper_zero;
    assign w_upper_zero[9] = (w_digits[9] == 4'd0);
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_upper_zero
            assign w_upper_zero[gi] = (w_digits[gi] == 4'd0) && w_upper_zero[gi+1];
        end
    endgenerate
    assign w_blank = (w_index_next != 3'd0) && w_upper_zero[{1'b0, w_index_next}];
`else
    assign w_blank = 1'b0;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_seg_next = w_blank ? 7'h7F : seg_decode(w_digit);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc <= '0;
            r_index <= '0;
            r_an    <= 8'hFE;
            r_seg   <= 7'h40;
        end else begin
            r_presc <= w_presc_next;
            r_index <= w_index_next;
            r_an    <= w_an_next;
            r_seg   <= w_seg_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_busy  = (r_state == ST_CONVERT);
    assign o_valid = r_valid;
    assign o_bcd   = r_bcd;
    assign o_ovf   = r_ovf;
    assign o_an    = r_an;
    assign o_seg   = r_seg;

endmodule

// File: tb/tb_count_display.sv
// -----------------------------------------------------------------------------
// tb_count_display
//
// Directed testbench for count_display with SCAN_DIV = 4. Drives a linear
// sequence of steps and checks outputs one cycle-edge at a time, 1 time unit
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_count_display;

    logic        clk;
    logic        reset;
    logic [31:0] result;
    logic        load;
    logic        busy;
    logic        valid;
    logic [39:0] bcd;
    logic        ovf;
    logic [7:0]  an;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    count_display #(.SCAN_DIV(4)) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_result (result),
        .i_load   (load),
        .o_busy   (busy),
        .o_valid  (valid),
        .o_bcd    (bcd),
        .o_ovf    (ovf),
        .o_an     (an),
        .o_seg    (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [31:0] v);
        result = v;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    // Runs until busy drops (bounded), counting busy cycles and valid pulses.
    // bcyc includes the cycle right after the accepting edge.
    task automatic run_to_idle(output int bcyc, output int vcnt);
        bcyc = busy ? 1 : 0;
        vcnt = valid ? 1 : 0;
        for (int g = 0; g < 100 && busy; g++) begin
            step();
            if (busy)  bcyc++;
            if (valid) vcnt++;
        end
        check("conversion_timeout_busy", {63'd0, busy}, 64'd0);
    endtask

    int         bcyc;
    int         vcnt;
    logic [7:0] prev_an;
    logic [6:0] exp_seg;
    logic [7:0] exp_an;
    logic [6:0] lead_seg;
    bit         synced;

    initial begin
        reset  = 1'b1;
        result = '0;
        load   = 1'b0;

        // ---- reset state ----
        repeat (3) step();
        check("reset_busy",  {63'd0, busy},  64'd0);
        check("reset_valid", {63'd0, valid}, 64'd0);
        check("reset_bcd",   {24'd0, bcd},   64'd0);
        check("reset_ovf",   {63'd0, ovf},   64'd0);
        check("reset_an",    {56'd0, an},    64'hFE);
        check("reset_seg",   {57'd0, seg},   64'h40);
        $display("reset: busy=%0b valid=%0b bcd=%h an=%h seg=%h", busy, valid, bcd, an, seg);
        reset = 1'b0;
        step();

        // ---- 12345678 ----
        start_load(32'd12345678);
        check("load1_busy_after_edge", {63'd0, busy}, 64'd1);
        run_to_idle(bcyc, vcnt);
        check("load1_valid_at_done", {63'd0, valid}, 64'd1);
        check("load1_busy_cycles", 64'(bcyc), 64'd32);
        check("load1_valid_pulses", 64'(vcnt), 64'd1);
        check("load1_bcd", {24'd0, bcd}, 64'h0012345678);
        check("load1_ovf", {63'd0, ovf}, 64'd0);
        step();
        check("load1_valid_clears", {63'd0, valid}, 64'd0);
        $display("conv 12345678: busy_cycles=%0d pulses=%0d bcd=%h ovf=%0b", bcyc, vcnt, bcd, ovf);

        // ---- 0xFFFFFFFF ----
        start_load(32'hFFFFFFFF);
        run_to_idle(bcyc, vcnt);
        check("max_bcd", {24'd0, bcd}, 64'h4294967295);
        check("max_ovf", {63'd0, ovf}, 64'd1);
        check("max_valid_pulses", 64'(vcnt), 64'd1);
        $display("conv FFFFFFFF: bcd=%h ovf=%0b", bcd, ovf);
        step();

        // ---- load dropped while busy ----
        start_load(32'd7);
        repeat (4) step();
        result = 32'd9;
        load   = 1'b1;
        step();
        load   = 1'b0;
        run_to_idle(bcyc, vcnt);
        check("drop_valid_pulses", 64'(vcnt), 64'd1);
        check("drop_bcd", {24'd0, bcd}, 64'h7);
        check("drop_ovf_cleared", {63'd0, ovf}, 64'd0);
        step();
        check("drop_no_second_busy", {63'd0, busy}, 64'd0);
        $display("drop test: pulses=%0d bcd=%h", vcnt, bcd);
        start_load(32'd9);
        run_to_idle(bcyc, vcnt);
        check("after_drop_bcd", {24'd0, bcd}, 64'h9);
        $display("reload 9: bcd=%h", bcd);
        step();

        // ---- load on the completion edge is ignored ----
        start_load(32'd1);
        repeat (31) step();
        check("edge_still_busy", {63'd0, busy}, 64'd1);
        check("edge_bcd_held", {24'd0, bcd}, 64'h9);
        result = 32'd5;
        load   = 1'b1;
        step();
        load   = 1'b0;
        check("edge_valid", {63'd0, valid}, 64'd1);
        check("edge_busy_low", {63'd0, busy}, 64'd0);
        check("edge_bcd", {24'd0, bcd}, 64'h1);
        step();
        check("edge_load_ignored", {63'd0, busy}, 64'd0);
        $display("load-on-completion: bcd=%h busy=%0b", bcd, busy);

        // ---- reset mid-conversion ----
        start_load(32'd99);
        repeat (9) step();
        reset = 1'b1;
        step();
        check("rstmid_busy", {63'd0, busy}, 64'd0);
        check("rstmid_valid", {63'd0, valid}, 64'd0);
        check("rstmid_bcd", {24'd0, bcd}, 64'd0);
        reset = 1'b0;
        vcnt  = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (valid) vcnt++;
        end
        check("rstmid_no_pulse", 64'(vcnt), 64'd0);
        check("rstmid_bcd_after", {24'd0, bcd}, 64'd0);
        $display("reset mid-conversion: busy=%0b bcd=%h pulses=%0d", busy, bcd, vcnt);

        // ---- scan with value 15 ----
        start_load(32'd15);
        run_to_idle(bcyc, vcnt);
        check("scan_bcd", {24'd0, bcd}, 64'h15);
        // Allow seg to pick up the new bcd, then align to the wrap back to digit 0.
        step();
        synced = 1'b0;
        for (int g = 0; g < 100 && !synced; g++) begin
            prev_an = an;
            step();
            if (prev_an != 8'hFE && an == 8'hFE) synced = 1'b1;
        end
        check("scan_sync", {63'd0, synced}, 64'd1);
`ifdef LEADING_ZERO_BLANK_EN
        lead_seg = 7'h7F;
`else
        lead_seg = 7'h40;
`endif
        for (int j = 0; j <= 32; j++) begin
            exp_an = ~(8'd1 << ((j / 4) % 8));
            case ((j / 4) % 8)
                0:       exp_seg = 7'h12;
                1:       exp_seg = 7'h79;
                default: exp_seg = lead_seg;
            endcase
            check($sformatf("scan_an_%0d", j), {56'd0, an}, {56'd0, exp_an});
            check($sformatf("scan_seg_%0d", j), {57'd0, seg}, {57'd0, exp_seg});
            if (j % 4 == 0) $display("scan cycle %0d: an=%h seg=%h", j, an, seg);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_display.md
# count_display

Downstream consumer of the 32-bit `counter` value. Captures a `result` word on a load strobe and converts it to 10-digit packed BCD with a sequential shift-add-3 (double-dabble) engine. It drives an 8-digit multiplexed, active-low seven-segment display from the last completed conversion. It sits between the counter stage and the board display pins.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays enabled; legal range ≥ 2.
- `clk`  input  1: single clock, all state updates on rising edge.
- `reset`  input  1: synchronous, active-high.
- `result`  input  32: binary value from the counter stage.
- `load`  input  1: capture request; sampled on a rising edge.
- `busy`  output  1: conversion in progress; `load` is ignored while high.
- `valid`  output  1: one-cycle pulse when `bcd` updates.
- `bcd`  output  40: packed BCD, digit k in bits [4k+3:4k], digit 0 = units.
- `ovf`  output  1: value ≥ 10^8 (digit 8 or 9 nonzero), so the display is truncated.
- `an`  output  8: digit enables, active-low; bit i = digit i.
- `seg`  output  7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- FSM has two states.
- IDLE: on `load`=1, copy `result` into a 32-bit shift register, clear a 40-bit BCD working register, clear the 5-bit iteration count, and go to CONVERT.
- CONVERT: each cycle, add 3 to every working BCD nibble ≥ 5, then shift {bcd_work, bin} left by 1.
  - After the 32nd iteration (count = 31), register the working value into `bcd`.
  - Set `ovf` = (bcd[39:32] != 0), pulse `valid`, and return to IDLE.
- `load` while `busy`=1: dropped, with no queueing and no effect on the conversion in flight.
- `bcd` and `ovf` hold their last completed value through later conversions until the next completion.
- Scan prescaler: counts 0..SCAN_DIV-1. On wrap, the digit index (3 bits) increments mod 8.
- `an` = ~(8'b1 << index).
- `seg` = decode of `bcd` digit[index]. Codes 0–9 use the standard patterns: 0 = 7'h40, 1 = 7'h79, 5 = 7'h12, 8 = 7'h00. Codes A–F cannot occur; map them to 7'h7F (blank).
- `an` and `seg` are registered and always change on the same edge.

## Timing
- Reset values:
  - State = IDLE; `busy`=0, `valid`=0, `bcd`=0, `ovf`=0.
  - Prescaler=0, index=0, `an`=8'hFE, `seg`=7'h40.
- Latency:
  - `load` sampled at edge N; `busy`=1 after edge N.
  - Conversion iterations occur at edges N+1..N+32.
  - `bcd`/`ovf` update and `valid`=1 after edge N+32; `busy`=0 after edge N+32.
  - `valid` clears after edge N+33.
- Earliest next accepted `load` is at edge N+33, giving one conversion per 33 cycles at maximum rate.
- `load` and completion on the same edge: completion takes effect; `load` is ignored because `busy` was high.
- Reset mid-conversion: back to IDLE on that edge, `bcd` cleared, no `valid` pulse.
- Digit switch: after edge k·SCAN_DIV (k ≥ 1) from reset, `an`/`seg` show digit k mod 8.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: digit i (i ≥ 1) shows `seg`=7'h7F when all of bcd digits i..9 are zero. Digit 0 always shows its value, so a value of 0 shows a single "0". `an` scanning is unchanged.
- Not defined: every digit shows its decoded value, including leading zeros (7'h40).

## Test plan
- Reset: hold `reset` 3 cycles → `busy`=0, `valid`=0, `bcd`=0, `ovf`=0, `an`=8'hFE, `seg`=7'h40.
- `load` with `result`=32'd12345678 → `busy` high exactly 32 cycles; a single `valid` pulse; `bcd`=40'h0012345678; `ovf`=0.
- `load` with `result`=32'hFFFFFFFF → `bcd`=40'h4294967295; `ovf`=1.
- `load` 32'd7 then `load` 32'd9 five cycles later → one `valid` pulse only; `bcd`=40'h7. A further `load` 32'd9 after `busy` falls → `bcd`=40'h9.
- SCAN_DIV=4, value 15:
  - `an` steps FE, FD, FB … 7F, changing every 4 cycles and wrapping back to FE.
  - `seg`: digit 0 = 7'h12, digit 1 = 7'h79.
  - Digits 2–7: 7'h40 without the macro, 7'h7F with it.
- `load` 32'd99, then assert `reset` 10 cycles later → `busy`=0 on the next cycle, no `valid` pulse, `bcd`=0.
